// File: rtl/uart_boot_loader_if.sv
// UART receive handshake and BRAM port B bundle shared by the boot loader.
// master: boot loader side (consumes UART bytes, drives port B).
// slave:  UART / BRAM side.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_re;
  logic [3:0]        bram_web;
  logic [ADDR_W-1:0] bram_addrb;
  logic [31:0]       bram_dinb;

  modport master (
    input  rx_data, rx_valid,
    output rx_re, bram_web, bram_addrb, bram_dinb
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_re, bram_web, bram_addrb, bram_dinb
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: holds the core in reset, downloads a length-prefixed
// little-endian word image over UART into BRAM port B, then releases the
// core and hands port B to it. Optional trailing XOR checksum byte is
// enabled by defining BOOT_CHECKSUM_EN.
//
// state     | meaning
// WAIT_HDR0 | waiting for count[7:0]; timeout boots the preloaded image
// WAIT_HDR1 | waiting for count[15:8]; validates the count
// RECV      | assembling the next 32-bit word, byte 0 first
// WRITE     | one-cycle port B write of the assembled word
// CHK       | waiting for the XOR checksum byte (BOOT_CHECKSUM_EN only)
// RUN       | core released, port B passed through from the core
// ERROR     | transfer failed, core held until reset
module uart_boot_loader #(
  parameter int ADDR_W         = 11,
  parameter int WORD_COUNT_MAX = 2048,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  uart_boot_loader_if.master bus,
  input  logic               cpu_mem_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic               cpu_hold,
  output logic               boot_busy,
  output logic               boot_done,
  output logic               boot_error,
  output logic [15:0]        words_loaded
);

  localparam int              TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     COUNT_MAX  = 16'(WORD_COUNT_MAX);

  typedef enum logic [2:0] {
    WAIT_HDR0 = 3'd0,
    WAIT_HDR1 = 3'd1,
    RECV      = 3'd2,
    WRITE     = 3'd3,
`ifdef BOOT_CHECKSUM_EN
    CHK       = 3'd4,
`endif
    RUN       = 3'd5,
    ERROR     = 3'd6
  } state_t;

  state_t            state;
  logic              rx_re_q;
  logic              rx_re_d;
  logic [TMR_W-1:0]  tmr;
  logic [15:0]       count_q;
  logic [1:0]        byte_idx;
  logic [23:0]       word_q;
  logic [3:0]        web_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif

  logic        accept_en;
  logic        accept;
  logic        timeout;
  logic        run;
  logic [15:0] hdr_count;

  // WRITE never accepts in practice: it is always entered on an accept,
  // so the rx_re guard below already blocks it.
`ifdef BOOT_CHECKSUM_EN
  assign accept_en = (state == WAIT_HDR0) || (state == WAIT_HDR1) ||
                     (state == RECV) || (state == CHK);
`else
  assign accept_en = (state == WAIT_HDR0) || (state == WAIT_HDR1) ||
                     (state == RECV);
`endif

  // rx_valid may still read high around the consume pulse, so bytes are
  // ignored while rx_re is high and for one cycle after it.
  assign accept    = accept_en && bus.rx_valid && !rx_re_q && !rx_re_d;
  assign timeout   = (tmr == '0) && !accept;
  assign hdr_count = {bus.rx_data, count_q[7:0]};
  assign run       = (state == RUN);

  // Port B belongs to the core from the edge the FSM enters RUN.
  assign bus.rx_re      = rx_re_q;
  assign bus.bram_web   = run ? {4{cpu_mem_we}} : web_q;
  assign bus.bram_addrb = run ? cpu_addr : addr_q;
  assign bus.bram_dinb  = run ? cpu_wdata : din_q;

  // Consume pulse and its one-cycle history for the accept guard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_re_q <= 1'b0;
      rx_re_d <= 1'b0;
    end else begin
      rx_re_q <= accept;
      rx_re_d <= rx_re_q;
    end
  end

  // Inter-byte timeout down-counter, reloaded by every accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr <= TMR_RELOAD;
    end else if (accept) begin
      tmr <= TMR_RELOAD;
    end else if (tmr != '0) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  // Boot sequencing FSM with registered status and port B write outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= WAIT_HDR0;
      cpu_hold     <= 1'b1;
      boot_busy    <= 1'b0;
      boot_done    <= 1'b0;
      boot_error   <= 1'b0;
      words_loaded <= '0;
      count_q      <= '0;
      byte_idx     <= '0;
      word_q       <= '0;
      web_q        <= '0;
      addr_q       <= '0;
      din_q        <= '0;
`ifdef BOOT_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      case (state)
        WAIT_HDR0: begin
          if (accept) begin
            count_q[7:0] <= bus.rx_data;
            boot_busy    <= 1'b1;
            state        <= WAIT_HDR1;
          end else if (timeout) begin
            cpu_hold <= 1'b0;
            state    <= RUN;
          end
        end
        WAIT_HDR1: begin
          if (accept) begin
            count_q[15:8] <= bus.rx_data;
            if (hdr_count == 16'd0) begin
              cpu_hold  <= 1'b0;
              boot_busy <= 1'b0;
              boot_done <= 1'b1;
              state     <= RUN;
            end else if (hdr_count > COUNT_MAX) begin
              boot_busy  <= 1'b0;
              boot_error <= 1'b1;
              state      <= ERROR;
            end else begin
              state <= RECV;
            end
          end else if (timeout) begin
            boot_busy  <= 1'b0;
            boot_error <= 1'b1;
            state      <= ERROR;
          end
        end
        RECV: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            xor_q    <= xor_q ^ bus.rx_data;
`endif
            case (byte_idx)
              2'd0: word_q[7:0]   <= bus.rx_data;
              2'd1: word_q[15:8]  <= bus.rx_data;
              2'd2: word_q[23:16] <= bus.rx_data;
              default: begin
                din_q  <= {bus.rx_data, word_q};
                addr_q <= words_loaded[ADDR_W-1:0];
                web_q  <= 4'hF;
                state  <= WRITE;
              end
            endcase
          end else if (timeout) begin
            boot_busy  <= 1'b0;
            boot_error <= 1'b1;
            state      <= ERROR;
          end
        end
        WRITE: begin
          web_q        <= 4'h0;
          words_loaded <= words_loaded + 16'd1;
          if (words_loaded + 16'd1 == count_q) begin
`ifdef BOOT_CHECKSUM_EN
            state <= CHK;
`else
            cpu_hold  <= 1'b0;
            boot_busy <= 1'b0;
            boot_done <= 1'b1;
            state     <= RUN;
`endif
          end else begin
            state <= RECV;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            boot_busy <= 1'b0;
            if (bus.rx_data == xor_q) begin
              cpu_hold  <= 1'b0;
              boot_done <= 1'b1;
              state     <= RUN;
            end else begin
              boot_error <= 1'b1;
              state      <= ERROR;
            end
          end else if (timeout) begin
            boot_busy  <= 1'b0;
            boot_error <= 1'b1;
            state      <= ERROR;
          end
        end
`endif
        RUN:   state <= RUN;
        ERROR: state <= ERROR;
        default: begin
          boot_busy  <= 1'b0;
          boot_error <= 1'b1;
          state      <= ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: expected port B writes are
// queued as bytes are issued and a monitor compares every write it sees.
module tb_uart_boot_loader;
  localparam int ADDR_W = 11;
  localparam int WMAX   = 2048;
  localparam int TMO    = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_mem_we;
  logic [10:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_hold, boot_busy, boot_done, boot_error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_W(ADDR_W)) bif ();

  uart_boot_loader #(
    .ADDR_W(ADDR_W), .WORD_COUNT_MAX(WMAX), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bif),
    .cpu_mem_we(cpu_mem_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_hold(cpu_hold), .boot_busy(boot_busy), .boot_done(boot_done),
    .boot_error(boot_error), .words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [3:0]  web;
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_re = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every port B write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bif.bram_web != 4'h0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: web=%h addr=%h data=%h, none expected",
                   bif.bram_web, bif.bram_addrb, bif.bram_dinb);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bif.bram_web, bif.bram_addrb, bif.bram_dinb} !== mon_e) begin
            errors++;
            $display("FAIL write: got web=%h addr=%h data=%h expected web=%h addr=%h data=%h",
                     bif.bram_web, bif.bram_addrb, bif.bram_dinb, mon_e.web, mon_e.addr, mon_e.data);
          end
        end
      end
      if (bif.rx_re) begin
        checks++;
        if (prev_re) begin
          errors++;
          $display("FAIL rx_re_width: got 2+ cycle pulse expected 1 cycle");
        end
      end
    end
    prev_re = bif.rx_re;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bif.rx_valid = 1'b0;
    cpu_mem_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_rx_re", bif.rx_re, 0);
    check("rst_bram_web", bif.bram_web, 0);
    check("rst_boot_busy", boot_busy, 0);
    check("rst_boot_done", boot_done, 0);
    check("rst_boot_error", boot_error, 0);
    check("rst_words_loaded", words_loaded, 0);
    check("rst_bram_addrb", bif.bram_addrb, 0);
    check("rst_bram_dinb", bif.bram_dinb, 0);
  endtask

  // Present one byte like the UART would; reports boot_error in the rx_re cycle.
  task automatic send_byte(input logic [7:0] b, input int gap, output logic err_at_re);
    bit seen = 0;
    err_at_re = 1'b0;
    @(posedge clk); #1;
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bif.rx_re) begin
        seen = 1;
        err_at_re = boot_error;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rx_consume: byte %h got no rx_re expected rx_re within 40 cycles", b);
    end
    @(posedge clk); #1;
    bif.rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_hold_low(input int max, output int n);
    bit seen = 0;
    n = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      n++;
      if (!cpu_hold) begin
        seen = 1;
        break;
      end
    end
    check("cpu_hold_release", seen, 1);
  endtask

  task automatic wait_error(input int max);
    bit seen = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (boot_error) begin
        seen = 1;
        break;
      end
    end
    check("boot_error_rise", seen, 1);
  endtask

  task automatic expect_loaded(input int cnt);
    int n;
    wait_hold_low(20, n);
    check("done_boot_done", boot_done, 1);
    check("done_boot_error", boot_error, 0);
    check("done_boot_busy", boot_busy, 0);
    check("done_words_loaded", words_loaded, cnt);
    check("done_pending_writes", exp_q.size(), 0);
  endtask

  // Random image: model words are whole 32-bit values; bytes go out LSB first.
  task automatic send_image(input int cnt, input int gap_max);
    logic [31:0] word;
    logic [7:0]  x = 8'h00;
    logic [15:0] c16;
    logic        e;
    c16 = 16'(cnt);
    send_byte(c16[7:0], $urandom_range(gap_max, 0), e);
    send_byte(c16[15:8], $urandom_range(gap_max, 0), e);
    for (int w = 0; w < cnt; w++) begin
      word = $urandom;
      exp_q.push_back({4'hF, 11'(w), word});
      for (int k = 0; k < 4; k++) begin
        x ^= word[8*k +: 8];
        send_byte(word[8*k +: 8], $urandom_range(gap_max, 0), e);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(x, 0, e);
`endif
    expect_loaded(cnt);
  endtask

  task automatic rx_ignored(input string name);
    @(posedge clk); #1;
    bif.rx_data  = 8'hA5;
    bif.rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check(name, bif.rx_re, 0);
    end
    @(posedge clk); #1;
    bif.rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] pl[8];
    logic [7:0] x;
    logic       e;
    int         n;

    rst = 1'b0;
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    cpu_mem_we = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    repeat (2) @(negedge clk);
    check_reset_state();
    #1 rst = 1'b1;
    check_reset_state();

    // Directed two-word image.
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    exp_q.push_back({4'hF, 11'd0, 32'h00000013});
    exp_q.push_back({4'hF, 11'd1, 32'h00100093});
    send_byte(8'h02, 1, e);
    check("hdr0_boot_busy", boot_busy, 1);
    send_byte(8'h00, 2, e);
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      x ^= pl[i];
      send_byte(pl[i], i % 3, e);
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(x, 0, e);
`endif
    expect_loaded(2);

    // Random images, then a full-size image at the count limit.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      send_image($urandom_range(6, 1), 3);
    end
    do_reset();
    send_image(WMAX, 0);

    // Silence after reset boots the preloaded image.
    do_reset();
    wait_hold_low(TMO + 20, n);
    checks++;
    if (n < TMO - 2 || n > TMO + 3) begin
      errors++;
      $display("FAIL hdr0_timeout_cycles: got %0d expected about %0d", n, TMO);
    end
    check("tmo_words_loaded", words_loaded, 0);
    check("tmo_boot_error", boot_error, 0);
    check("tmo_boot_done", boot_done, 0);

    // RUN: port B follows the core combinationally; UART bytes ignored.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cpu_addr   = 11'($urandom_range(2047, 0));
      cpu_wdata  = $urandom;
      cpu_mem_we = (i % 2 == 0);
      if (cpu_mem_we) exp_q.push_back({4'hF, cpu_addr, cpu_wdata});
      #1;
      check("run_addrb", bif.bram_addrb, cpu_addr);
      check("run_dinb", bif.bram_dinb, cpu_wdata);
      check("run_web", bif.bram_web, {4{cpu_mem_we}});
    end
    @(posedge clk); #1;
    cpu_addr   = 11'h010;
    cpu_wdata  = 32'hDEADBEEF;
    cpu_mem_we = 1'b1;
    exp_q.push_back({4'hF, 11'h010, 32'hDEADBEEF});
    @(posedge clk); #1;
    cpu_mem_we = 1'b0;
    @(negedge clk);
    check("run_pending_writes", exp_q.size(), 0);
    rx_ignored("run_rx_re");

    // Mid-word silence -> ERROR, no write.
    do_reset();
    send_byte(8'h01, 0, e);
    send_byte(8'h00, 0, e);
    send_byte(8'h11, 0, e);
    send_byte(8'h22, 0, e);
    wait_error(2 * TMO);
    check("tmo_err_cpu_hold", cpu_hold, 1);
    check("tmo_err_boot_done", boot_done, 0);
    check("tmo_err_boot_busy", boot_busy, 0);
    check("tmo_err_words", words_loaded, 0);
    rx_ignored("err_rx_re");

    // Oversized count -> ERROR in the cycle after the second header byte.
    do_reset();
    send_byte(8'h01, 0, e);
    send_byte(8'h08, 0, e);
    check("oversize_err_at_hdr1", e, 1);
    check("oversize_cpu_hold", cpu_hold, 1);

    // Zero count -> RUN with boot_done.
    do_reset();
    send_byte(8'h00, 0, e);
    send_byte(8'h00, 0, e);
    expect_loaded(0);

    // Reset in mid-transfer aborts; next image restarts at address 0.
    do_reset();
    exp_q.push_back({4'hF, 11'd0, 32'h44332211});
    send_byte(8'h03, 0, e);
    send_byte(8'h00, 0, e);
    send_byte(8'h11, 0, e);
    send_byte(8'h22, 0, e);
    send_byte(8'h33, 0, e);
    send_byte(8'h44, 0, e);
    send_byte(8'h55, 0, e);
    check("abort_pending_writes", exp_q.size(), 0);
    check("abort_busy_before", boot_busy, 1);
    do_reset();
    check_reset_state();
    send_image(3, 2);

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    exp_q.push_back({4'hF, 11'd0, 32'h44332211});
    send_byte(8'h01, 0, e);
    send_byte(8'h00, 0, e);
    send_byte(8'h11, 0, e);
    send_byte(8'h22, 0, e);
    send_byte(8'h33, 0, e);
    send_byte(8'h44, 0, e);
    send_byte(8'h44, 0, e);
    expect_loaded(1);

    do_reset();
    exp_q.push_back({4'hF, 11'd0, 32'h44332211});
    send_byte(8'h01, 0, e);
    send_byte(8'h00, 0, e);
    send_byte(8'h11, 0, e);
    send_byte(8'h22, 0, e);
    send_byte(8'h33, 0, e);
    send_byte(8'h44, 0, e);
    send_byte(8'h45, 0, e);
    check("chk_bad_error", e, 1);
    check("chk_bad_cpu_hold", cpu_hold, 1);
    check("chk_bad_boot_done", boot_done, 0);
    check("chk_bad_pending", exp_q.size(), 0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Boot controller that owns BRAM data port B and the UART receiver at power-up. It holds the core in reset, downloads a program image over UART into the shared instruction/data BRAM, then hands port B and the UART back to the pipeline. It sits between the UART RX/MMIO logic, the dual-port BRAM (port B) and the core's reset input.

## Interface
Parameters:
- ADDR_W, 11, BRAM word-address width (2048 x 32).
- WORD_COUNT_MAX, 2048, largest accepted image size in words.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  byte available; cleared by the UART one cycle after rx_re.
- rx_re  out  1  one-cycle byte-consume pulse.
- cpu_mem_we  in  1  core data-port write enable (EX/MEM stage).
- cpu_addr  in  ADDR_W  core data word address.
- cpu_wdata  in  32  core store data.
- bram_web  out  4  port B byte write enables.
- bram_addrb  out  ADDR_W  port B word address.
- bram_dinb  out  32  port B write data.
- cpu_hold  out  1  1 = core held in reset and stalled.
- boot_busy  out  1  image transfer in progress.
- boot_done  out  1  image fully loaded (sticky until reset).
- boot_error  out  1  transfer failed (sticky until reset).
- words_loaded  out  16  count of words written in this boot.

## Operation
- States: WAIT_HDR0, WAIT_HDR1, RECV, WRITE, CHK (macro only), RUN, ERROR.
- Byte accept, in every state except RUN/ERROR: if rx_valid=1 and rx_re was 0 in the previous cycle, capture rx_data and drive rx_re=1 for exactly one cycle. rx_valid is ignored in the cycle after rx_re.
- WAIT_HDR0: the first byte is count[7:0] -> WAIT_HDR1. A timeout here means no host is present -> RUN with the preloaded BRAM image, words_loaded=0.
- WAIT_HDR1: the byte is count[15:8].
  - count=0 -> RUN with boot_done=1.
  - count>WORD_COUNT_MAX -> ERROR.
  - Otherwise -> RECV.
- RECV: assemble the word little-endian with a byte index from 0 to 3. After byte 3 -> WRITE.
- WRITE: for one cycle drive bram_web=4'hF, bram_addrb=words_loaded[ADDR_W-1:0], bram_dinb=word; words_loaded increments.
  - If words_loaded+1 == count -> RUN (or CHK with the macro) and boot_done=1.
  - Otherwise -> RECV.
- The timeout counter reloads on every accepted byte. A timeout in WAIT_HDR1, RECV or CHK -> ERROR.
- ERROR: cpu_hold=1 and boot_error=1; rx_re stays 0. The state is left only by reset.
- RUN: cpu_hold=0 and rx_re=0. Port B is combinationally passed through: bram_web={4{cpu_mem_we}}, bram_addrb=cpu_addr, bram_dinb=cpu_wdata.
- In all states other than RUN and WRITE, bram_web=0.
- boot_busy=1 in WAIT_HDR1, RECV, WRITE and CHK.

## Timing
- Reset values: state WAIT_HDR0, cpu_hold=1, rx_re=0, bram_web=0, boot_busy=0, boot_done=0, boot_error=0, words_loaded=0. bram_addrb and bram_dinb are 0.
- rx_re is registered and rises on the edge after rx_valid is sampled high.
- Each word is written one cycle after its 4th byte is accepted.
- cpu_hold is registered. It falls on the same edge the state becomes RUN, and the port B mux switches on that same edge.
- Assertion of rst mid-transfer aborts immediately and returns to WAIT_HDR0. Words already written stay in BRAM.
- words_loaded wraps never: its maximum value is WORD_COUNT_MAX.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - After the last WRITE, go to CHK and accept one more byte.
  - That byte must equal the XOR of all payload bytes. Match -> RUN; mismatch -> ERROR. boot_done is set only on a match.
- BOOT_CHECKSUM_EN undefined: there is no CHK state, and the last WRITE goes straight to RUN.

## Test plan
- Header 02 00, payload 13 00 00 00 93 00 10 00:
  - Port B is written with 0x00000013 at address 0, then 0x00100093 at address 1, each with bram_web=F for 1 cycle.
  - Afterwards cpu_hold=0, boot_done=1, words_loaded=2.
- No byte for TIMEOUT_CYCLES after reset -> RUN, cpu_hold=0, words_loaded=0, boot_error=0, no port B writes.
- Header 01 00, then bytes 11 22, then silence for TIMEOUT_CYCLES -> ERROR, boot_error=1, cpu_hold=1, no write issued.
- Header 01 08 (count 0x0801 > 2048) -> ERROR on the cycle after the second header byte.
- In RUN:
  - cpu_mem_we=1, cpu_addr=0x010, cpu_wdata=0xDEADBEEF -> same-cycle bram_web=F, bram_addrb=0x010, bram_dinb=0xDEADBEEF.
  - rx_valid pulses leave rx_re=0.
- BOOT_CHECKSUM_EN, header 01 00, payload 11 22 33 44:
  - Checksum byte 44 -> boot_done=1, RUN.
  - Checksum byte 45 -> ERROR, cpu_hold=1.
